serial_eq_checker: RTL and testbench

- Downstream consumer of the per-bit XNOR equality stage. It compares two serial bit streams, a and b, over a fixed-length frame.
- Per bit: eq = a XNOR b. Across the frame it accumulates the match count, records the index of the first mismatching bit, and reports an all-match verdict.
- It is the frame-level checker used after the bit-level equality gate in compare and self-test paths.

---
 rtl/serial_eq_pkg.sv | 24 ++
 rtl/serial_eq_checker_xnor_eq_cell.sv | 10 +
 rtl/serial_eq_checker.sv | 114 +++++++++++
 tb/tb_serial_eq_checker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_eq_pkg.sv
// Shared types and width helpers for the serial frame equality checker.
package serial_eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FRAME_LEN_DEF = 8;

    // Number of bits needed to encode values 0..n-1 (ceil(log2(n))).
    function automatic int calc_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_eq_checker_xnor_eq_cell.sv
// Single-bit equality gate: eq is high when both stream bits agree.
module xnor_eq_cell (
    input  logic a,
    input  logic b,
    output logic eq
);

    assign eq = a ~^ b;

endmodule

// File: rtl/serial_eq_checker.sv
// Frame-level checker for two serial bit streams: counts matching bits,
// records the first mismatch position and reports an all-match verdict.
module serial_eq_checker
    import serial_eq_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = calc_w(FRAME_LEN + 1),
    parameter int IDX_W     = calc_w(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             all_match,
    output logic             mm_seen,
    output logic [IDX_W-1:0] first_mm_idx
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt_n;
    logic [IDX_W-1:0] fidx_n;
    logic             busy_n, done_n, all_n, mm_n;
    logic             eq;

    xnor_eq_cell u_eq (
        .a  (a),
        .b  (b),
        .eq (eq)
    );

    // Next-state and next-result logic; everything holds unless a rule fires.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = match_cnt;
        fidx_n  = first_mm_idx;
        busy_n  = busy;
        done_n  = 1'b0;
        all_n   = all_match;
        mm_n    = mm_seen;
        case (state)
            IDLE: begin
                // bit_valid alongside start is deliberately ignored here.
                if (start) begin
                    state_n = RUN;
                    busy_n  = 1'b1;
                    idx_n   = '0;
                    cnt_n   = '0;
                    fidx_n  = '0;
                    mm_n    = 1'b0;
                    all_n   = 1'b0;
                end
            end
            RUN: begin
                if (bit_valid) begin
                    if (eq) begin
                        cnt_n = match_cnt + CNT_W'(1);
                    end else if (!mm_seen) begin
                        fidx_n = idx;
                        mm_n   = 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        // Last bit: idx stays put so it never exceeds FRAME_LEN-1.
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        all_n   = (cnt_n == FULL_CNT);
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            match_cnt    <= '0;
            first_mm_idx <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            all_match    <= 1'b0;
            mm_seen      <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            match_cnt    <= cnt_n;
            first_mm_idx <= fidx_n;
            busy         <= busy_n;
            done         <= done_n;
            all_match    <= all_n;
            mm_seen      <= mm_n;
        end
    end

endmodule

// File: tb/tb_serial_eq_checker.sv
// Bench for serial_eq_checker (FRAME_LEN = 8): directed frames plus
// randomized frames checked against a frame-level reference model.
module tb_serial_eq_checker;

    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       rst, start, bit_valid, a, b;
    logic       busy, done, all_match, mm_seen;
    logic [3:0] match_cnt;
    logic [2:0] first_mm_idx;

    int n_vec = 0;
    int n_mm  = 0;

    serial_eq_checker #(.FRAME_LEN(FL)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_valid    (bit_valid),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .match_cnt    (match_cnt),
        .all_match    (all_match),
        .mm_seen      (mm_seen),
        .first_mm_idx (first_mm_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mm++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cnt"}, 32'(match_cnt), 0);
        check({tag, "_all"}, 32'(all_match), 0);
        check({tag, "_mm"}, 32'(mm_seen), 0);
        check({tag, "_fidx"}, 32'(first_mm_idx), 0);
    endtask

    // Run one frame: av/bv bit i is frame bit i. gap < 0 means random 0..3.
    task automatic run_frame(input string tag, input logic [7:0] av, input logic [7:0] bv,
                             input int gap, input bit noisy, input bit vld_at_start);
        int exp_cnt, exp_fidx, g;
        bit exp_mm;
        exp_cnt  = 0;
        exp_fidx = 0;
        exp_mm   = 0;
        for (int i = 0; i < FL; i++) begin
            if (av[i] == bv[i]) exp_cnt++;
            else if (!exp_mm) begin
                exp_mm   = 1;
                exp_fidx = i;
            end
        end

        start     = 1'b1;
        bit_valid = vld_at_start;
        a         = 1'b1;
        b         = 1'b0;
        step();
        start     = 1'b0;
        bit_valid = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 1);

        for (int i = 0; i < FL; i++) begin
            a         = av[i];
            b         = bv[i];
            bit_valid = 1'b1;
            step();
            bit_valid = 1'b0;
            if (i < FL - 1) begin
                check({tag, "_no_early_done"}, 32'(done), 0);
                g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
                for (int k = 0; k < g; k++) begin
                    a     = 1'($urandom);
                    b     = 1'($urandom);
                    start = noisy ? 1'($urandom) : 1'b0;
                    step();
                    check({tag, "_gap_no_done"}, 32'(done), 0);
                end
                start = 1'b0;
            end
        end

        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_end"}, 32'(busy), 0);
        check({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt));
        check({tag, "_all"}, 32'(all_match), 32'(exp_cnt == FL));
        check({tag, "_mm"}, 32'(mm_seen), 32'(exp_mm));
        check({tag, "_fidx"}, 32'(first_mm_idx), 32'(exp_fidx));
        step();
        check({tag, "_done_one_cycle"}, 32'(done), 0);
        check({tag, "_hold_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] ra, rb;

        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // 1: all bits equal
        run_frame("t1", 8'hA5, 8'hA5, 0, 1'b0, 1'b0);
        // 2: a all ones, b = 1,1,0,1,0,1,1,1
        run_frame("t2", 8'hFF, 8'hEB, 0, 1'b0, 1'b0);
        // 3: same data with 3-cycle gaps and start pulses during RUN
        run_frame("t3", 8'hFF, 8'hEB, 3, 1'b1, 1'b0);
        // 4: mismatch only on the last bit
        run_frame("t4", 8'hFF, 8'h7F, 0, 1'b0, 1'b0);

        // 5: reset mid-frame after 4 bits
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 1'b1; b = 1'(i & 1); bit_valid = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("t5_midreset");
        for (int i = 0; i < 3; i++) begin
            a = 1'b1; b = 1'b1; bit_valid = 1'b1;
            step();
            check("t5_no_done_after_reset", 32'(done), 0);
            check("t5_idle_not_busy", 32'(busy), 0);
        end
        bit_valid = 1'b0;
        run_frame("t5_fresh", 8'h3C, 8'h3C, 0, 1'b0, 1'b0);

        // 6: bit_valid with start is ignored; results hold while idle
        run_frame("t6", 8'h00, 8'h00, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t6_hold_cnt", 32'(match_cnt), 8);
            check("t6_hold_all", 32'(all_match), 1);
            check("t6_hold_done", 32'(done), 0);
        end

        // Randomized frames with random gaps and stray starts
        for (int f = 0; f < 20; f++) begin
            ra = 8'($urandom);
            rb = (f % 4 == 0) ? ra : 8'($urandom);
            run_frame("rand", ra, rb, -1, 1'b1, 1'($urandom));
            for (int k = 0; k < int'($urandom_range(2, 0)); k++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mm);
        $finish;
    end

endmodule
